// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator: counter/LFSR data, first beat one cycle after start, 1 beat/cycle.
// Backpressure: tdata/tlast hold while tready is low; tvalid never depends on tready combinationally.
module axis_traffic_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  num_pkts,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t                 state;
  logic                   mode_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_idx;
  logic [CNT_WIDTH-1:0]   num_q;
  logic [CNT_WIDTH-1:0]   pkt_idx;
  logic                   hs;

  assign hs = m_axis_tvalid & m_axis_tready;

  function automatic logic [DATA_WIDTH-1:0] next_data(input logic m,
                                                      input logic [DATA_WIDTH-1:0] d);
    if (m)
      return {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1] ^ d[21] ^ d[1] ^ d[0]};
    else
      return d + DATA_WIDTH'(1);
  endfunction

  // busy covers SEND and FIN, so it drops together with the done pulse.
  always_ff @(posedge m_axis_clk) begin
    if (m_axis_rst) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      len_q         <= '0;
      num_q         <= '0;
      beat_idx      <= '0;
      pkt_idx       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q       <= mode;
            len_q        <= pkt_len;
            num_q        <= num_pkts;
            beat_idx     <= '0;
            pkt_idx      <= '0;
            busy         <= 1'b1;
            // An all-zero LFSR state would lock up, so it is nudged to 1.
            m_axis_tdata <= (mode && seed == '0) ? DATA_WIDTH'(1) : seed;
            m_axis_tlast <= (pkt_len == LEN_WIDTH'(1));
            if (pkt_len == '0 || num_pkts == '0) begin
              state         <= FIN;
              done          <= 1'b1;
              m_axis_tvalid <= 1'b0;
            end else begin
              state         <= SEND;
              m_axis_tvalid <= 1'b1;
            end
          end
        end

        SEND: begin
          if (hs) begin
            m_axis_tdata <= next_data(mode_q, m_axis_tdata);
            if (m_axis_tlast) begin
              beat_idx <= '0;
              pkt_idx  <= pkt_idx + CNT_WIDTH'(1);
              if (pkt_idx == num_q - CNT_WIDTH'(1)) begin
                state         <= FIN;
                done          <= 1'b1;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
              end else begin
                m_axis_tlast <= (len_q == LEN_WIDTH'(1));
              end
            end else begin
              beat_idx     <= beat_idx + LEN_WIDTH'(1);
              m_axis_tlast <= (beat_idx + LEN_WIDTH'(1) == len_q - LEN_WIDTH'(1));
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: per-cycle trace capture with hand-computed expectations.
module tb_axis_traffic_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  pkt_len = '0;
  logic [7:0]  num_pkts = '0;
  logic [31:0] seed = '0;
  logic        tready = 1'b0;
  logic        tvalid, tlast, busy, done;
  logic [31:0] tdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic        tr_vld[$], tr_last[$], tr_rdy[$], tr_busy[$], tr_done[$];
  logic [31:0] tr_dat[$];
  logic [31:0] bdat[$];
  logic        blast[$];

  axis_traffic_gen #(.DATA_WIDTH(32), .LEN_WIDTH(8), .CNT_WIDTH(8)) dut (
    .m_axis_clk(clk), .m_axis_rst(rst), .start(start), .mode(mode),
    .pkt_len(pkt_len), .num_pkts(num_pkts), .seed(seed),
    .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic m, input logic [31:0] s, input logic [7:0] l, input logic [7:0] n);
    mode = m; seed = s; pkt_len = l; num_pkts = n; start = 1'b1;
  endtask

  // Records ncyc cycles; rdy_pat 0 = always ready, 1 = ready every third cycle.
  task automatic run(input int ncyc, input int rdy_pat, input int start_at);
    tr_vld.delete(); tr_last.delete(); tr_rdy.delete(); tr_busy.delete(); tr_done.delete();
    tr_dat.delete(); bdat.delete(); blast.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      tready = (rdy_pat == 0) ? 1'b1 : (i % 3 == 0);
      if (i == start_at) launch(1'b0, 32'h999, 8'd3, 8'd1);
      tr_vld.push_back(tvalid); tr_dat.push_back(tdata); tr_last.push_back(tlast);
      tr_rdy.push_back(tready); tr_busy.push_back(busy); tr_done.push_back(done);
      if (tvalid && tready) begin
        bdat.push_back(tdata);
        blast.push_back(tlast);
      end
    end
  endtask

  function automatic int count_of(input int which);
    int c = 0;
    for (int i = 0; i < tr_vld.size(); i++)
      case (which)
        0: c += int'(tr_vld[i]);
        1: c += int'(tr_busy[i]);
        default: c += int'(tr_done[i]);
      endcase
    return c;
  endfunction

  function automatic int first_done();
    for (int i = 0; i < tr_done.size(); i++)
      if (tr_done[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tready = 1'b1;
    launch(1'b0, 32'h55, 8'd4, 8'd2);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", tlast); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", tdata); end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_launch got vld=%b busy=%b want 0 0", tvalid, busy); end
  endtask

  task automatic test_basic();
    logic all_vld = 1'b1;
    launch(1'b0, 32'h10, 8'd4, 8'd2);
    run(12, 0, -1);
    n_checks++; if (bdat.size() != 8) begin n_fail++; $display("FAIL basic_beats got %0d want 8", bdat.size()); end
    for (int k = 0; k < 8 && k < bdat.size(); k++) begin
      n_checks++; if (bdat[k] !== 32'h10 + k) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", k, bdat[k], 32'h10 + k); end
      n_checks++; if (blast[k] !== (k == 3 || k == 7)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", k, blast[k], (k == 3 || k == 7)); end
    end
    for (int i = 0; i < 8; i++) all_vld &= tr_vld[i];
    n_checks++; if (all_vld !== 1'b1) begin n_fail++; $display("FAIL basic_no_bubble got %b want 1", all_vld); end
    n_checks++; if (first_done() != 8) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 8", first_done()); end
    n_checks++; if (count_of(2) != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", count_of(2)); end
    n_checks++; if (count_of(1) != 9) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 9", count_of(1)); end
  endtask

  task automatic test_stall();
    launch(1'b0, 32'h10, 8'd4, 8'd2);
    run(30, 1, -1);
    n_checks++; if (bdat.size() != 8) begin n_fail++; $display("FAIL stall_beats got %0d want 8", bdat.size()); end
    for (int k = 0; k < 8 && k < bdat.size(); k++) begin
      n_checks++; if (bdat[k] !== 32'h10 + k || blast[k] !== (k == 3 || k == 7))
        begin n_fail++; $display("FAIL stall_beat[%0d] got %h/%b want %h/%b", k, bdat[k], blast[k], 32'h10 + k, (k == 3 || k == 7)); end
    end
    for (int i = 0; i + 1 < tr_vld.size(); i++)
      if (tr_vld[i] && !tr_rdy[i]) begin
        n_checks++;
        if (tr_vld[i+1] !== 1'b1 || tr_dat[i+1] !== tr_dat[i] || tr_last[i+1] !== tr_last[i])
          begin n_fail++; $display("FAIL stall_hold[%0d] got %b/%h/%b want 1/%h/%b", i, tr_vld[i+1], tr_dat[i+1], tr_last[i+1], tr_dat[i], tr_last[i]); end
      end
    n_checks++; if (count_of(0) != 22) begin n_fail++; $display("FAIL stall_vld_cycles got %0d want 22", count_of(0)); end
    n_checks++; if (first_done() != 22) begin n_fail++; $display("FAIL stall_done_cycle got %0d want 22", first_done()); end
  endtask

  task automatic test_lfsr_wrap();
    launch(1'b1, 32'h0, 8'd2, 8'd1);
    run(5, 0, -1);
    n_checks++; if (bdat.size() != 2 || bdat[0] !== 32'h1 || bdat[1] !== 32'h3)
      begin n_fail++; $display("FAIL lfsr_seed0 got n=%0d %h %h want 2 00000001 00000003", bdat.size(), tr_dat[0], tr_dat[1]); end
    launch(1'b1, 32'h8000_0000, 8'd2, 8'd1);
    run(5, 0, -1);
    n_checks++; if (bdat.size() != 2 || bdat[0] !== 32'h8000_0000 || bdat[1] !== 32'h1)
      begin n_fail++; $display("FAIL lfsr_msb got n=%0d %h %h want 2 80000000 00000001", bdat.size(), tr_dat[0], tr_dat[1]); end
    launch(1'b0, 32'hFFFF_FFFF, 8'd2, 8'd1);
    run(5, 0, -1);
    n_checks++; if (bdat.size() != 2 || bdat[0] !== 32'hFFFF_FFFF || bdat[1] !== 32'h0 || blast[1] !== 1'b1)
      begin n_fail++; $display("FAIL count_wrap got n=%0d %h %h want 2 ffffffff 00000000", bdat.size(), tr_dat[0], tr_dat[1]); end
  endtask

  task automatic test_zero();
    for (int z = 0; z < 2; z++) begin
      if (z == 0) launch(1'b0, 32'h5, 8'd0, 8'd3);
      else        launch(1'b0, 32'h5, 8'd5, 8'd0);
      run(4, 0, -1);
      n_checks++; if (count_of(0) != 0) begin n_fail++; $display("FAIL zero%0d_vld got %0d want 0", z, count_of(0)); end
      n_checks++; if (count_of(2) != 1 || first_done() != 0) begin n_fail++; $display("FAIL zero%0d_done got n=%0d at %0d want 1 at 0", z, count_of(2), first_done()); end
      n_checks++; if (count_of(1) != 1) begin n_fail++; $display("FAIL zero%0d_busy got %0d want 1", z, count_of(1)); end
    end
  endtask

  task automatic test_reset_mid();
    tready = 1'b1;
    launch(1'b0, 32'h100, 8'd6, 8'd1);
    repeat (3) begin @(posedge clk); #1; start = 1'b0; end
    n_checks++; if (tdata !== 32'h102 || tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_beat3 got %h/%b want 00000102/1", tdata, tvalid); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== 32'h0)
      begin n_fail++; $display("FAIL mid_reset got vld=%b busy=%b data=%h want 0 0 0", tvalid, busy, tdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    launch(1'b0, 32'h300, 8'd2, 8'd1);
    run(5, 0, -1);
    n_checks++; if (bdat.size() != 2 || bdat[0] !== 32'h300 || bdat[1] !== 32'h301)
      begin n_fail++; $display("FAIL mid_restart got n=%0d %h %h want 2 00000300 00000301", bdat.size(), tr_dat[0], tr_dat[1]); end
  endtask

  task automatic test_start_ignored();
    launch(1'b0, 32'h200, 8'd4, 8'd1);
    run(10, 0, 2);
    n_checks++; if (bdat.size() != 4) begin n_fail++; $display("FAIL ign_beats got %0d want 4", bdat.size()); end
    for (int k = 0; k < 4 && k < bdat.size(); k++) begin
      n_checks++; if (bdat[k] !== 32'h200 + k) begin n_fail++; $display("FAIL ign_data[%0d] got %h want %h", k, bdat[k], 32'h200 + k); end
    end
    n_checks++; if (count_of(2) != 1 || count_of(0) != 4) begin n_fail++; $display("FAIL ign_done_vld got done=%0d vld=%0d want 1 4", count_of(2), count_of(0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_lfsr_wrap();
    test_zero();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
